// File: rtl/sprite_draw_scheduler.sv
// sprite_draw_scheduler
//   Time-shares one VGA adapter plot port between N_SPR sprite engines.
//   Each frame_tick starts a round. The sprites enabled in the mask latched at
//   that tick are granted one at a time, in ascending index order. A grant is a
//   one-cycle spr_en pulse. The scheduler then waits for that sprite's spr_done,
//   or for the watchdog to expire, and moves on.
//   While a sprite is being waited on, its x/y/colour/plot are steered onto vga_*.
//
// Ports
//   clk, reset                   clock, asynchronous active-high reset
//   frame_tick                   one-cycle round start pulse
//   spr_mask[N_SPR]              sprites taking part, sampled on an accepted tick
//   spr_done[N_SPR]              per-sprite finish pulse
//   spr_plot/spr_x/spr_y/spr_colour  packed per-sprite plot requests
//   clear_err                    clears the sticky error flags
//   spr_en[N_SPR]                one-hot grant pulse
//   vga_x/vga_y/vga_colour/vga_plot  muxed plot port (zero outside WAIT)
//   busy, round_done, active_idx round status
//   timeout_err, timeout_idx     sticky watchdog flag and last offending sprite
//   overrun_err                  sticky: tick arrived while a round was running
module sprite_draw_scheduler #(
    parameter int N_SPR   = 4,
    parameter int TIMEOUT = 200000,
    parameter int TMR_W   = 18
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_tick,
    input  logic [N_SPR-1:0]     spr_mask,
    input  logic [N_SPR-1:0]     spr_done,
    input  logic [N_SPR-1:0]     spr_plot,
    input  logic [8*N_SPR-1:0]   spr_x,
    input  logic [7*N_SPR-1:0]   spr_y,
    input  logic [3*N_SPR-1:0]   spr_colour,
    input  logic                 clear_err,
    output logic [N_SPR-1:0]     spr_en,
    output logic [7:0]           vga_x,
    output logic [6:0]           vga_y,
    output logic [2:0]           vga_colour,
    output logic                 vga_plot,
    output logic                 busy,
    output logic                 round_done,
    output logic [2:0]           active_idx,
    output logic                 timeout_err,
    output logic [2:0]           timeout_idx,
    output logic                 overrun_err
);

    typedef enum logic [2:0] {S_IDLE, S_GRANT, S_WAIT, S_NEXT, S_RDONE} state_t;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_t             state;
    logic [N_SPR-1:0]   mask_q;
    logic [2:0]         idx;
    logic [TMR_W-1:0]   timer;

    // Lowest set bit of m at or above position lo; MSB of result is "found".
    function automatic logic [3:0] find_set(input logic [N_SPR-1:0] m, input int lo);
        logic [3:0] r;
        r = '0;
        for (int i = N_SPR - 1; i >= 0; i--) begin
            if (i >= lo && m[i]) r = {1'b1, 3'(i)};
        end
        return r;
    endfunction

    function automatic logic [N_SPR-1:0] onehot(input logic [2:0] b);
        logic [N_SPR-1:0] r;
        r = '0;
        for (int i = 0; i < N_SPR; i++) begin
            if (b == 3'(i)) r[i] = 1'b1;
        end
        return r;
    endfunction

    logic [3:0] first_hit;
    logic [3:0] next_hit;

    assign first_hit = find_set(spr_mask, 0);
    assign next_hit  = find_set(mask_q, int'(idx) + 1);

    // Signals of the currently selected sprite.
    logic       sel_done;
    logic       sel_plot;
    logic [7:0] sel_x;
    logic [6:0] sel_y;
    logic [2:0] sel_colour;

    always_comb begin
        sel_done   = 1'b0;
        sel_plot   = 1'b0;
        sel_x      = '0;
        sel_y      = '0;
        sel_colour = '0;
        for (int i = 0; i < N_SPR; i++) begin
            if (idx == 3'(i)) begin
                sel_done   = spr_done[i];
                sel_plot   = spr_plot[i];
                sel_x      = spr_x[8*i +: 8];
                sel_y      = spr_y[7*i +: 7];
                sel_colour = spr_colour[3*i +: 3];
            end
        end
    end

    // The plot port is only driven while waiting on a sprite, so a sprite's
    // requests never leak into GRANT/NEXT cycles or into another sprite's slot.
    assign vga_plot   = (state == S_WAIT) ? sel_plot   : 1'b0;
    assign vga_x      = (state == S_WAIT) ? sel_x      : '0;
    assign vga_y      = (state == S_WAIT) ? sel_y      : '0;
    assign vga_colour = (state == S_WAIT) ? sel_colour : '0;

    assign active_idx = idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            mask_q      <= '0;
            idx         <= '0;
            timer       <= '0;
            spr_en      <= '0;
            busy        <= 1'b0;
            round_done  <= 1'b0;
            timeout_err <= 1'b0;
            timeout_idx <= '0;
            overrun_err <= 1'b0;
        end else begin
            spr_en     <= '0;
            round_done <= 1'b0;

            // Clear first so that an error raised in the same cycle wins.
            if (clear_err) begin
                timeout_err <= 1'b0;
                timeout_idx <= '0;
                overrun_err <= 1'b0;
            end
            if (frame_tick && state != S_IDLE) overrun_err <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (frame_tick) begin
                        mask_q <= spr_mask;
                        busy   <= 1'b1;
                        if (first_hit[3]) begin
                            idx    <= first_hit[2:0];
                            spr_en <= onehot(first_hit[2:0]);
                            state  <= S_GRANT;
                        end else begin
                            round_done <= 1'b1;
                            state      <= S_RDONE;
                        end
                    end
                end
                S_GRANT: begin
                    timer <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // Done is tested first so it beats a coinciding timeout.
                    if (sel_done) begin
                        state <= S_NEXT;
                    end else if (timer == TMR_LAST) begin
                        timeout_err <= 1'b1;
                        timeout_idx <= idx;
                        state       <= S_NEXT;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_NEXT: begin
                    if (next_hit[3]) begin
                        idx    <= next_hit[2:0];
                        spr_en <= onehot(next_hit[2:0]);
                        state  <= S_GRANT;
                    end else begin
                        round_done <= 1'b1;
                        state      <= S_RDONE;
                    end
                end
                S_RDONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
